mem_port_arbiter: RTL

Two-master arbiter that shares the single 256-bit off-chip data-memory port between the instruction-cache refill path (master 0) and the `dcache_top` miss/write-back path (master 1). Sits between the CPU's cache controllers and `Data_Memory`. It serialises their line-sized read/write transactions with round-robin priority. Each master sees the same enable/ack handshake that `dcache_top` already speaks.

---
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of one 256-bit line port
// between the icache refill (m0) and the dcache miss/wb path (m1).
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   mX_enable_i         request, held until mX_ack_o
//   mX_write_i          1 = write, 0 = read
//   mX_addr_i           line address
//   mX_data_i           write data
//   mX_data_o           read data, valid with mX_ack_o
//   mX_ack_o            one-cycle completion pulse
//   mem_enable_o        memory request (high through BUSY)
//   mem_write_o         memory write
//   mem_addr_o          memory address
//   mem_data_o          memory write data
//   mem_data_i          memory read data, valid with mem_ack_i
//   mem_ack_i           memory completion pulse
//   grant_o             one-hot owner ({m1,m0}), 00 when idle
//   err_o               sticky: memory ack seen outside BUSY
module mem_port_arbiter #(
   parameter int DATA_W = 256,
   parameter int ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              m0_enable_i,
   input  logic              m0_write_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_data_i,
   output logic [DATA_W-1:0] m0_data_o,
   output logic              m0_ack_o,
   input  logic              m1_enable_i,
   input  logic              m1_write_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_data_i,
   output logic [DATA_W-1:0] m1_data_o,
   output logic              m1_ack_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_data_o,
   input  logic [DATA_W-1:0] mem_data_i,
   input  logic              mem_ack_i,
   output logic [1:0]        grant_o,
   output logic              err_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t              r_state;
   // Last-granted master; also the owner while BUSY/DONE.
   logic                r_last;
   logic                r_mem_enable;
   logic                r_mem_write;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_data;
   logic [DATA_W-1:0]   r_m0_data;
   logic [DATA_W-1:0]   r_m1_data;
   logic                r_m0_ack;
   logic                r_m1_ack;
   logic [1:0]          r_grant;
   logic                r_err;

   logic                w_req_any;
   logic                w_winner;

   assign w_req_any = m0_enable_i | m1_enable_i;
   // On contention the master not granted last goes first;
   // a lone requester always wins.
   assign w_winner  = (m0_enable_i & m1_enable_i) ? ~r_last
                                                  : m1_enable_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= S_IDLE;
         r_last       <= 1'b0;
         r_mem_enable <= 1'b0;
         r_mem_write  <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_data   <= '0;
         r_m0_data    <= '0;
         r_m1_data    <= '0;
         r_m0_ack     <= 1'b0;
         r_m1_ack     <= 1'b0;
         r_grant      <= 2'b00;
         r_err        <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (mem_ack_i) begin
                  r_err <= 1'b1;
               end
               if (w_req_any) begin
                  r_last       <= w_winner;
                  r_grant      <= w_winner ? 2'b10 : 2'b01;
                  r_mem_enable <= 1'b1;
                  r_mem_write  <= w_winner ? m1_write_i : m0_write_i;
                  r_mem_addr   <= w_winner ? m1_addr_i  : m0_addr_i;
                  r_mem_data   <= w_winner ? m1_data_i  : m0_data_i;
                  r_state      <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (mem_ack_i) begin
                  r_mem_enable <= 1'b0;
                  r_state      <= S_DONE;
                  if (r_last) begin
                     r_m1_ack <= 1'b1;
                     if (!r_mem_write) begin
                        r_m1_data <= mem_data_i;
                     end
                  end else begin
                     r_m0_ack <= 1'b1;
                     if (!r_mem_write) begin
                        r_m0_data <= mem_data_i;
                     end
                  end
               end
            end
            S_DONE: begin
               if (mem_ack_i) begin
                  r_err <= 1'b1;
               end
               r_m0_ack <= 1'b0;
               r_m1_ack <= 1'b0;
               r_grant  <= 2'b00;
               r_state  <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign m0_data_o    = r_m0_data;
   assign m0_ack_o     = r_m0_ack;
   assign m1_data_o    = r_m1_data;
   assign m1_ack_o     = r_m1_ack;
   assign mem_enable_o = r_mem_enable;
   assign mem_write_o  = r_mem_write;
   assign mem_addr_o   = r_mem_addr;
   assign mem_data_o   = r_mem_data;
   assign grant_o      = r_grant;
   assign err_o        = r_err;

endmodule
